// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus memory target serving 8-beat (64-byte) line bursts.
// Ports: clk, reset (sync, active-low); bus_reqcyc/bus_req/bus_reqtag/bus_reqack request side;
//   bus_respcyc/bus_resp/bus_resptag/bus_respack response side.
// Build option: define MEMRESP_WRAP_BURST_EN for critical-word-first wrapping burst order.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif
`ifndef SYSBUS_MMIO
`define SYSBUS_MMIO 4'b0011
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 256,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW = $clog2(MEM_WORDS);
  // only the line bits that land inside the memory are kept
  localparam int LW = AW - 3;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_RESP
  } state_e;

  state_e                   state_q, state_d;
  logic [LW-1:0]            line_q, line_d;
  logic [2:0]               beat_q, beat_d;
  logic [CW-1:0]            wait_q, wait_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [2:0]               word;
  logic [AW-1:0]            idx;
  logic                     mem_we;
  logic                     req_rw;
  logic [3:0]               req_dev;

  logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS] = '{default: '0};

`ifdef MEMRESP_WRAP_BURST_EN
  logic [2:0] start_q, start_d;
  assign word = start_q + beat_q;
`else
  assign word = beat_q;
`endif

  assign idx     = {line_q, word};
  assign req_rw  = bus_reqtag[BUS_TAG_WIDTH-1];
  assign req_dev = bus_reqtag[BUS_TAG_WIDTH-2 -: 4];

  assign bus_reqack  = reset && bus_reqcyc &&
                       (state_q == IDLE || state_q == WR_DATA);
  assign bus_respcyc = reset && (state_q == RD_RESP);
  assign bus_resp    = bus_respcyc ? mem_q[idx] : '0;
  assign bus_resptag = bus_respcyc ? tag_q : '0;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    tag_d   = tag_q;
    mem_we  = 1'b0;
`ifdef MEMRESP_WRAP_BURST_EN
    start_d = start_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus_reqack) begin
          line_d = bus_req[AW+2:6];
          beat_d = 3'd0;
          wait_d = '0;
          tag_d  = bus_reqtag;
`ifdef MEMRESP_WRAP_BURST_EN
          start_d = bus_req[5:3];
`endif
          // foreign devices are acked and dropped
          if (req_dev == `SYSBUS_MEMORY) begin
            state_d = (req_rw == `SYSBUS_READ) ? RD_WAIT : WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (bus_reqack) begin
          mem_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = RD_RESP;
        else wait_d = wait_q + CW'(1);
      end
      RD_RESP: begin
        if (bus_respack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      tag_q   <= '0;
`ifdef MEMRESP_WRAP_BURST_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      tag_q   <= tag_d;
`ifdef MEMRESP_WRAP_BURST_EN
      start_q <= start_d;
`endif
    end
  end

  // storage survives reset; writes are already gated by reqack
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= bus_req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: vector table, directed bursts and random traffic
// against a transaction-level memory model.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif
`ifndef SYSBUS_MMIO
`define SYSBUS_MMIO 4'b0011
`endif

module tb_sysbus_mem_responder;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int MW = 256;
  localparam int LAT = 4;
  localparam logic RD = `SYSBUS_READ;
  localparam logic WR = `SYSBUS_WRITE;
  localparam logic [3:0] MEM = `SYSBUS_MEMORY;
  localparam logic [3:0] MMIO = `SYSBUS_MMIO;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bus_reqcyc = 1'b0;
  logic bus_respack = 1'b0;
  logic [DW-1:0] bus_req = '0;
  logic [TW-1:0] bus_reqtag = '0;
  logic bus_reqack, bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [MW];

  always #5 clk = ~clk;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW),
    .MEM_WORDS(MW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  typedef struct {
    logic rst;
    logic reqcyc;
    logic [TW-1:0] tag;
    logic [63:0] req;
    logic respack;
    logic ack;
    logic rc;
    logic [63:0] resp;
    logic [TW-1:0] rtag;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [TW-1:0] mk_tag(logic rw, logic [3:0] dev,
                                           logic [7:0] id);
    return {rw, dev, id};
  endfunction

  function automatic vec_t v(logic rst, logic reqcyc, logic [TW-1:0] tag,
                             logic [63:0] req, logic respack, logic ack,
                             logic rc, logic [63:0] resp,
                             logic [TW-1:0] rtag);
    vec_t r;
    r.rst = rst; r.reqcyc = reqcyc; r.tag = tag; r.req = req;
    r.respack = respack; r.ack = ack; r.rc = rc; r.resp = resp;
    r.rtag = rtag;
    return r;
  endfunction

  // memory word hit by beat b of a burst addressed at addr
  function automatic int idx_of(logic [63:0] addr, int b);
    longint unsigned w;
`ifdef MEMRESP_WRAP_BURST_EN
    w = (longint'(addr[5:3]) + longint'(b)) % 8;
`else
    w = longint'(b);
`endif
    return int'(((longint'(addr >> 6) * 8) + w) % MW);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_burst(input logic [63:0] addr, input logic [7:0] id,
                          input logic [63:0] d [8], input int abort_at,
                          input bit gaps);
    bus_reqcyc = 1'b1;
    bus_req = addr;
    bus_reqtag = mk_tag(WR, MEM, id);
    bus_respack = 1'b0;
    #1;
    chk("wr_addr_ack", bus_reqack, 1);
    chk("wr_addr_rc", bus_respcyc, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus_reqcyc = 1'b0;
          #1;
          chk("wr_gap_ack", bus_reqack, 0);
          step();
        end
      end
      bus_reqcyc = 1'b1;
      bus_req = d[i];
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk("wr_rst_ack", bus_reqack, 0);
        step();
        reset = 1'b1;
        bus_reqcyc = 1'b0;
        return;
      end
      #1;
      chk($sformatf("wr_b%0d_ack", i), bus_reqack, 1);
      chk($sformatf("wr_b%0d_rc", i), bus_respcyc, 0);
      mdl[idx_of(addr, i)] = d[i];
      step();
    end
    bus_reqcyc = 1'b0;
    #1;
    chk("wr_end_rc", bus_respcyc, 0);
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [7:0] id,
                          input int stall_beat, input int stall_len,
                          input bit rnd_stall, input int abort_at);
    logic [TW-1:0] t;
    logic [63:0] exp;
    int s;
    t = mk_tag(RD, MEM, id);
    bus_reqcyc = 1'b1;
    bus_req = addr;
    bus_reqtag = t;
    bus_respack = 1'b0;
    #1;
    chk("rd_acc_ack", bus_reqack, 1);
    chk("rd_acc_rc", bus_respcyc, 0);
    step();
    // keep requesting: nothing may be accepted during the read
    bus_reqtag = mk_tag(RD, MMIO, 8'hEE);
    for (int c = 0; c < LAT; c++) begin
      bus_respack = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rd_wait%0d_rc", c), bus_respcyc, 0);
      chk($sformatf("rd_wait%0d_ack", c), bus_reqack, 0);
      step();
    end
    for (int b = 0; b < 8; b++) begin
      exp = mdl[idx_of(addr, b)];
      if (b == abort_at) begin
        reset = 1'b0;
        bus_respack = 1'b1;
        #1;
        chk("rd_rst_rc", bus_respcyc, 0);
        chk("rd_rst_resp", bus_resp, 0);
        chk("rd_rst_tag", bus_resptag, 0);
        chk("rd_rst_ack", bus_reqack, 0);
        step();
        reset = 1'b1;
        bus_reqcyc = 1'b0;
        bus_respack = 1'b0;
        #1;
        chk("rd_postrst_rc", bus_respcyc, 0);
        return;
      end
      if (b == stall_beat) s = stall_len;
      else if (rnd_stall) s = $urandom_range(0, 2);
      else s = 0;
      for (int k = 0; k <= s; k++) begin
        bus_respack = (k == s);
        #1;
        chk($sformatf("rd_b%0d_rc", b), bus_respcyc, 1);
        chk($sformatf("rd_b%0d_data", b), bus_resp, exp);
        chk($sformatf("rd_b%0d_tag", b), bus_resptag, t);
        chk($sformatf("rd_b%0d_ack", b), bus_reqack, 0);
        step();
      end
    end
    bus_respack = 1'b0;
    bus_reqcyc = 1'b0;
    #1;
    chk("rd_end_rc", bus_respcyc, 0);
    chk("rd_end_resp", bus_resp, 0);
    chk("rd_end_tag", bus_resptag, 0);
  endtask

  task automatic other_dev(input logic [3:0] dev, input logic [7:0] id);
    bus_reqcyc = 1'b1;
    bus_req = {$urandom, $urandom};
    bus_reqtag = mk_tag(1'($urandom_range(0, 1)), dev, id);
    bus_respack = 1'b0;
    #1;
    chk("dev_ack", bus_reqack, 1);
    step();
    bus_reqcyc = 1'b0;
    repeat (2) begin
      bus_respack = 1'b1;
      #1;
      chk("dev_norc", bus_respcyc, 0);
      step();
    end
    bus_respack = 1'b0;
  endtask

  initial begin
    logic [63:0] d [8];
    logic [TW-1:0] t11;
    int kind;
    for (int i = 0; i < MW; i++) mdl[i] = '0;
    t11 = mk_tag(RD, MEM, 8'h11);

    tbl.push_back(v(0, 1, mk_tag(RD, MEM, 8'h01), 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, mk_tag(RD, MMIO, 8'h02), 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, mk_tag(RD, 4'h7, 8'h03), 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, t11, 64'h2000, 1, 1, 0, 0, 0));
    for (int i = 0; i < LAT; i++)
      tbl.push_back(v(1, 1, mk_tag(RD, MEM, 8'h12), 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, t11));
    tbl.push_back(v(1, 1, mk_tag(WR, MEM, 8'h13), 0, 0, 0, 1, 0, t11));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, mk_tag(WR, MEM, 8'h20), 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      bus_reqcyc = tbl[i].reqcyc;
      bus_reqtag = tbl[i].tag;
      bus_req = tbl[i].req;
      bus_respack = tbl[i].respack;
      #1;
      chk($sformatf("vec%0d_ack", i), bus_reqack, tbl[i].ack);
      chk($sformatf("vec%0d_rc", i), bus_respcyc, tbl[i].rc);
      chk($sformatf("vec%0d_resp", i), bus_resp, tbl[i].resp);
      chk($sformatf("vec%0d_tag", i), bus_resptag, tbl[i].rtag);
      step();
    end

    for (int i = 0; i < 8; i++) d[i] = 64'hFFFF_FFFF_FFFF_FFFF - 64'(i);
    wr_burst(64'h1000, 8'h00, d, 8, 1'b0);
    rd_burst(64'h1000, 8'h05, 8, 0, 1'b0, 8);
    rd_burst(64'h1000, 8'h06, 2, 3, 1'b0, 8);
    rd_burst(64'h1028, 8'h07, 8, 0, 1'b0, 8);
    rd_burst(64'h1000, 8'h08, 8, 0, 1'b0, 3);
    rd_burst(64'h1000, 8'h09, 8, 0, 1'b0, 8);
    other_dev(MMIO, 8'h0A);
    rd_burst(64'h1028, 8'h0B, 8, 0, 1'b0, 8);
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    wr_burst(64'h1068, 8'h0C, d, 3, 1'b0);
    rd_burst(64'h1040, 8'h0D, 8, 0, 1'b0, 8);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        wr_burst({$urandom, $urandom}, 8'($urandom), d, 8, 1'b1);
      end else if (kind < 9) begin
        rd_burst({$urandom, $urandom}, 8'($urandom), 8, 0, 1'b1, 8);
      end else begin
        other_dev(MMIO, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, 64, width of request and response data.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, 13, tag width: {rw bit, 4-bit device, 8-bit id} per Sysbus.defs.
REQ-003 SHALL have parameter MEM_WORDS, 256, 64-bit words of internal storage (power of 2).
REQ-004 SHALL have parameter LATENCY, 4, idle cycles between read accept and first response beat (>=1).
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  clock, all state updates on posedge.
REQ-007 reset  input  1  synchronous active-low reset (0 = reset).
REQ-008 bus_reqcyc  input  1  initiator request valid.
REQ-009 bus_req  input  BUS_DATA_WIDTH  address beat, then write data beats.
REQ-010 bus_reqtag  input  BUS_TAG_WIDTH  request tag.
REQ-011 bus_reqack  output  1  request beat accepted this cycle.
REQ-012 bus_respcyc  output  1  response beat valid.
REQ-013 bus_resp  output  BUS_DATA_WIDTH  read data beat.
REQ-014 bus_resptag  output  BUS_TAG_WIDTH  tag of the request being answered.
REQ-015 bus_respack  input  1  initiator consumed response beat this cycle.

Function
REQ-016 States SHALL be IDLE, WR_DATA, RD_WAIT, RD_RESP; all bursts are 8 beats (one 64-byte line).
REQ-017 bus_reqack SHALL be combinational: 1 iff bus_reqcyc=1 and state is IDLE or WR_DATA; 0 in RD_WAIT/RD_RESP (new requests stall during a read).
REQ-018 IDLE, accepted beat: latch line = bus_req[63:6], start word = bus_req[5:3], tag = bus_reqtag, beat counter = 0.
REQ-019 IDLE -> RD_WAIT if tag rw bit = `SYSBUS_READ and device = `SYSBUS_MEMORY; -> WR_DATA if rw bit = `SYSBUS_WRITE and device = `SYSBUS_MEMORY.
REQ-020 Accepted beats with device != `SYSBUS_MEMORY SHALL be acked and dropped, state stays IDLE, no response.
REQ-021 Word index for beat b SHALL be {line, word(b)} modulo MEM_WORDS; word(b) per REQ-038/039; 3-bit word arithmetic wraps mod 8.
REQ-022 WR_DATA: each accepted beat SHALL store bus_req to the indexed word and increment b; after beat 7 -> IDLE; no response issued for writes.
REQ-023 RD_WAIT: counter SHALL run LATENCY cycles; bus_respcyc first 1 exactly LATENCY+1 cycles after the accept cycle.
REQ-024 RD_RESP: bus_respcyc=1, bus_resp = memory[index(b)], bus_resptag = latched tag; values held stable while bus_respack=0.
REQ-025 bus_respack=1 with bus_respcyc=1 SHALL advance b; after beat 7 acked -> IDLE, bus_respcyc 0 the next cycle.
REQ-026 bus_respack while bus_respcyc=0 SHALL be ignored.
REQ-027 A read accepted after a write completes SHALL return the written data.
REQ-028 bus_resp and bus_resptag SHALL be 0 whenever bus_respcyc=0.
REQ-029 Memory SHALL initialise to all zero at time 0.

Reset
REQ-030 reset=0 at posedge SHALL force state IDLE, counters 0, latched tag 0; bus_respcyc, bus_resp, bus_resptag 0 and bus_reqack 0 while reset=0.
REQ-031 Reset mid-burst SHALL abort the burst; words already written remain; no further beats.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 First request SHALL be acceptable the first cycle after reset deasserts.

Configuration
REQ-034 Macro MEMRESP_WRAP_BURST_EN SHALL select burst word order.
REQ-035 Defined: word(b) = start word + b mod 8 (critical-word-first, wraps within line), for reads and writes.
REQ-036 Undefined: word(b) = b (line-aligned from word 0); address bits [5:3] ignored.
REQ-037 Both builds SHALL keep identical handshake timing.
REQ-038 Order rule for reads SHALL be REQ-035 or REQ-036 per macro.
REQ-039 Order rule for writes SHALL be the same as reads.

Verification
REQ-040 Write 0x1000 tag {WRITE,MEMORY,0x00}, data 0xFFFF_FFFF_FFFF_FFFF..0xFFFF_FFFF_FFFF_FFF8 -> 9 reqacks, no respcyc, state IDLE.
REQ-041 Then read 0x1000 tag {READ,MEMORY,0x05}, LATENCY=4 -> respcyc at accept+5, 8 beats ...FFFF..., ...FFF8 in order, resptag {READ,MEMORY,0x05}.
REQ-042 Read with respack held 0 for 3 cycles on beat 2 -> beat 2 data/tag stable 4 cycles; reqcyc during that time gets reqack=0.
REQ-043 With MEMRESP_WRAP_BURST_EN, read 0x1028 -> word order 5,6,7,0,1,2,3,4; without -> 0..7.
REQ-044 reset=0 for one cycle during beat 3 of a read -> respcyc 0 next cycle, IDLE; new read accepted right after, full 8 beats.
REQ-045 Request tag device = `SYSBUS_MMIO -> acked once, no response, next memory request served normally.
